// File: rtl/sha1_if.sv
// Handshake/bus bundle between a block producer and the SHA-1 compression core.
//   block_i/blockvalid_i/blockready_o : 512-bit message block handshake
//   init_i                            : start-new-message flag sampled with the block
//   digest_o/digestvalid_o/digestack_i: 160-bit digest and its acknowledge
//   busy_o                            : compression in progress
// The _i/_o suffixes are from the core's point of view.
interface sha1_if;
  logic [511:0] block_i;
  logic         blockvalid_i;
  logic         blockready_o;
  logic         init_i;
  logic [159:0] digest_o;
  logic         digestvalid_o;
  logic         digestack_i;
  logic         busy_o;

  modport master (
    output block_i, blockvalid_i, init_i, digestack_i,
    input  blockready_o, digest_o, digestvalid_o, busy_o
  );

  modport slave (
    input  block_i, blockvalid_i, init_i, digestack_i,
    output blockready_o, digest_o, digestvalid_o, busy_o
  );
endinterface

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression engine: one 512-bit block per handshake,
// 80 rounds at one round per clock, then the working variables are added
// into the chaining state H, which is presented as the digest until acked.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : sha1_if.slave (block handshake, init flag, digest handshake, busy)
module sha1_core (
  input  logic   clk_i,
  input  logic   rst_ni,
  sha1_if.slave  bus
);

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_e;

  state_e      state_q, state_d;
  logic [6:0]  t_q;
  logic [31:0] a_q, b_q, c_q, d_q, e_q;
  logic [31:0] h_q [5];
  logic [31:0] w_q [16];

  logic [3:0]  idx, i3, i8, i14;
  logic [31:0] w_new, w_t, temp;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  function automatic logic [31:0] f_fn(input logic [6:0] t,
                                       input logic [31:0] b, c, d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_fn(input logic [6:0] t);
    if (t < 7'd20)      return 32'h5A827999;
    else if (t < 7'd40) return 32'h6ED9EBA1;
    else if (t < 7'd60) return 32'h8F1BBCDC;
    else                return 32'hCA62C1D6;
  endfunction

  // Circular schedule buffer: slot t mod 16 holds W[t-16] until overwritten.
  // W[t-3], W[t-8], W[t-14] live at slots idx+13, idx+8, idx+2 (mod 16).
  always_comb begin
    idx   = t_q[3:0];
    i3    = idx + 4'd13;
    i8    = idx + 4'd8;
    i14   = idx + 4'd2;
    w_new = rotl1(w_q[i3] ^ w_q[i8] ^ w_q[i14] ^ w_q[idx]);
    w_t   = (t_q < 7'd16) ? w_q[idx] : w_new;
    temp  = rotl5(a_q) + f_fn(t_q, b_q, c_q, d_q) + e_q + k_fn(t_q) + w_t;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.blockvalid_i)  state_d = ROUND;
      ROUND:   if (t_q == 7'd79)      state_d = UPDATE;
      UPDATE:                         state_d = DONE;
      DONE:    if (bus.digestack_i)   state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int i = 0; i < 5; i++)  h_q[i] <= IV[159-32*i -: 32];
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.blockvalid_i) begin
          if (bus.init_i) begin
            for (int i = 0; i < 5; i++) h_q[i] <= IV[159-32*i -: 32];
            a_q <= IV[159:128];
            b_q <= IV[127:96];
            c_q <= IV[95:64];
            d_q <= IV[63:32];
            e_q <= IV[31:0];
          end else begin
            a_q <= h_q[0];
            b_q <= h_q[1];
            c_q <= h_q[2];
            d_q <= h_q[3];
            e_q <= h_q[4];
          end
          for (int i = 0; i < 16; i++) w_q[i] <= bus.block_i[511-32*i -: 32];
          t_q <= '0;
        end
        ROUND: begin
          a_q <= temp;
          b_q <= a_q;
          c_q <= rotl30(b_q);
          d_q <= c_q;
          e_q <= d_q;
          t_q <= t_q + 7'd1;
          if (t_q >= 7'd16) w_q[idx] <= w_new;
        end
        UPDATE: begin
          h_q[0] <= h_q[0] + a_q;
          h_q[1] <= h_q[1] + b_q;
          h_q[2] <= h_q[2] + c_q;
          h_q[3] <= h_q[3] + d_q;
          h_q[4] <= h_q[4] + e_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.blockready_o  = (state_q == IDLE);
  assign bus.busy_o        = (state_q == ROUND) || (state_q == UPDATE);
  assign bus.digestvalid_o = (state_q == DONE);
  assign bus.digest_o      = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};

endmodule

// File: tb/tb_sha1_core.sv
module tb_sha1_core;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
    32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
    32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2 = {{15{32'h0}}, 32'h000001C0};
  localparam logic [159:0] D_ABC   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
  localparam logic [159:0] D_EMPTY = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;
  localparam logic [159:0] D_TWO   = 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  sha1_if bus ();
  sha1_core dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  logic [159:0] h_model;

  typedef struct {
    logic [511:0] blk;
    logic         init;
    logic         has_exp;
    logic [159:0] exp;
  } vec_t;

  vec_t vecs[4];

  // Reference model: straight from the SHA-1 definition with a full 80-word schedule.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [159:0] ref_compress(input logic [159:0] hin,
                                                input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int t = 0; t < 80; t++) begin
      case (t / 20)
        0: begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
        1: begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
        2: begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        default: begin f = b ^ c ^ d;             k = 32'hCA62C1D6; end
      endcase
      tmp = rl(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rl(b, 30); b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Presents a block at a negedge; returns just after the handshake edge.
  task automatic send(input logic [511:0] blk, input logic init);
    @(negedge clk);
    chk("ready_before_send", {159'h0, bus.blockready_o}, 160'h1);
    bus.block_i = blk;
    bus.init_i = init;
    bus.blockvalid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.blockvalid_i = 1'b0;
  endtask

  // Counts edges from the handshake until digestvalid_o, and busy cycles.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = bus.busy_o ? 1 : 0;
    while (!bus.digestvalid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy_o) busy_n++;
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.digestack_i = 1'b1;
    @(posedge clk);
    #1;
    bus.digestack_i = 1'b0;
    chk("ready_after_ack", {159'h0, bus.blockready_o}, 160'h1);
  endtask

  task automatic run_and_check(input string name, input logic [511:0] blk,
                               input logic init, input logic [159:0] exp);
    int lat, bsy;
    send(blk, init);
    wait_done(lat, bsy);
    chk({name, "_latency"}, 160'(lat), 160'd81);
    chk({name, "_busy_cycles"}, 160'(bsy), 160'd81);
    chk({name, "_digest"}, bus.digest_o, exp);
    h_model = compress_chain(blk, init);
    do_ack();
  endtask

  function automatic logic [159:0] compress_chain(input logic [511:0] blk, input logic init);
    return ref_compress(init ? IV : h_model, blk);
  endfunction

  initial begin
    int lat, bsy;
    logic [159:0] held;
    logic [511:0] rblk;
    logic rinit;

    bus.block_i = '0;
    bus.blockvalid_i = 1'b0;
    bus.init_i = 1'b0;
    bus.digestack_i = 1'b0;
    h_model = IV;

    vecs[0] = '{BLK_ABC,   1'b1, 1'b1, D_ABC};
    vecs[1] = '{BLK_EMPTY, 1'b1, 1'b1, D_EMPTY};
    vecs[2] = '{BLK_TWO1,  1'b1, 1'b0, 160'h0};
    vecs[3] = '{BLK_TWO2,  1'b0, 1'b1, D_TWO};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_digest", bus.digest_o, IV);
    chk("reset_ready", {159'h0, bus.blockready_o}, 160'h1);
    chk("reset_valid", {159'h0, bus.digestvalid_o}, 160'h0);
    chk("reset_busy", {159'h0, bus.busy_o}, 160'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Known-answer table: abc, empty (init overrides chaining), two-block message.
    for (int i = 0; i < 4; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].blk, vecs[i].init,
                    vecs[i].has_exp ? vecs[i].exp : compress_chain(vecs[i].blk, vecs[i].init));
    end

    // Backpressure: digest held while ack is low, block inputs ignored.
    send(BLK_ABC, 1'b1);
    wait_done(lat, bsy);
    h_model = IV;
    h_model = compress_chain(BLK_ABC, 1'b1);
    held = bus.digest_o;
    chk("bp_digest", held, D_ABC);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.blockvalid_i = 1'($urandom & 1);
      bus.block_i = {16{$urandom}};
      bus.init_i = 1'($urandom & 1);
      @(posedge clk);
      #1;
      chk("bp_hold", {bus.digest_o == held, bus.blockready_o, bus.digestvalid_o},
          {1'b1, 1'b0, 1'b1});
    end
    // Ack with a block already valid: must not be taken on the ack edge.
    @(negedge clk);
    bus.digestack_i = 1'b1;
    bus.blockvalid_i = 1'b1;
    bus.block_i = BLK_ABC;
    bus.init_i = 1'b1;
    @(posedge clk);
    #1;
    bus.digestack_i = 1'b0;
    chk("ack_edge_no_accept", {158'h0, bus.blockready_o, bus.busy_o}, 160'b10);
    @(posedge clk);
    #1;
    bus.blockvalid_i = 1'b0;
    wait_done(lat, bsy);
    chk("bp_abc_latency", 160'(lat), 160'd81);
    chk("bp_abc_digest", bus.digest_o, D_ABC);
    do_ack();

    // Reset during round 40.
    send(BLK_ABC, 1'b1);
    repeat (40) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midreset_state", {bus.digest_o, bus.digestvalid_o, bus.blockready_o, bus.busy_o},
        {IV, 3'b010});
    @(negedge clk);
    rst_ni = 1'b1;
    h_model = IV;
    run_and_check("after_reset_abc", BLK_ABC, 1'b1, D_ABC);

    // Random blocks with random init, checked against the chained model.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 16; j++) rblk[511-32*j -: 32] = $urandom;
      rinit = (i == 0) ? 1'b1 : 1'($urandom & 1);
      run_and_check($sformatf("rand%0d", i), rblk, rinit, compress_chain(rblk, rinit));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
